// File: rtl/iir_step_ctrl.sv
// iir_step_ctrl -- sample-rate sequencer for the FP biquad datapath.
//
// Divides clk down to the sample rate (one tick every T clocks), launches one
// sample per tick onto the datapath, holds dp_en high for exactly LAT clocks,
// then strobes the delay-line shift and captures the filter output.
//
// Ports:
//   clk, reset_l      system clock, asynchronous active-low reset
//   i_en              run enable for the tick counter / new launches
//   i_valid, i_signal fresh input sample and its qualifier
//   dp_q              datapath result (valid LAT clocks after dp_a changes)
//   dp_a              sample presented to the datapath (changes only on launch)
//   dp_en             datapath pipeline enable (LAT cycles per sample)
//   o_upd             one-cycle delay-line shift strobe
//   o_signal, o_valid filtered output (held) and its one-cycle update pulse
//   o_overrun         sticky: tick arrived while a sample was in flight
//   o_stale           sticky: tick arrived without i_valid
//   o_flush           (IIR_NAN_GUARD_EN only) clear the delay line instead of
//                     shifting when dp_q is Inf/NaN
//
// Build option: define IIR_NAN_GUARD_EN to enable the Inf/NaN guard at commit.
//
// State  | meaning
// IDLE   | waiting for a sample tick
// RUN    | datapath enabled, rlat counting down the pipeline latency
// COMMIT | dp_q valid: shift delay line, capture result
module iir_step_ctrl #(
  parameter int T          = 50,
  parameter int LAT        = 12,
  parameter int W          = 32,
  // Clearing this skips the T/LAT legality check (only for overrun testing).
  parameter bit CHK_PARAMS = 1'b1
) (
  input  logic         clk,
  input  logic         reset_l,
  input  logic         i_en,
  input  logic         i_valid,
  input  logic [W-1:0] i_signal,
  input  logic [W-1:0] dp_q,
  output logic [W-1:0] dp_a,
  output logic         dp_en,
  output logic         o_upd,
  output logic [W-1:0] o_signal,
  output logic         o_valid,
  output logic         o_overrun,
  output logic         o_stale
`ifdef IIR_NAN_GUARD_EN
  ,
  output logic         o_flush
`endif
);

  localparam int CW = (T > 1) ? $clog2(T) : 1;
  localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;

  generate
    if (CHK_PARAMS && ((LAT < 1) || (T < LAT + 3))) begin : g_bad_params
      $error("iir_step_ctrl: illegal parameters, need LAT>=1 and T>=LAT+3");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, COMMIT} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [LW-1:0] rlat;
  logic          tick;
  logic          launch;
  logic          dp_nan;

  assign tick   = i_en && (cnt == CW'(T - 1));
  assign launch = tick && (state == IDLE);

`ifdef IIR_NAN_GUARD_EN
  // Exponent all-ones covers both Inf and NaN.
  assign dp_nan  = (dp_q[W-2 -: 8] == 8'hFF);
  assign o_flush = (state == COMMIT) && dp_nan;
`else
  assign dp_nan  = 1'b0;
`endif

  // Strobes decoded from state so reset clears them immediately.
  assign dp_en = (state == RUN);
  assign o_upd = (state == COMMIT) && !dp_nan;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      cnt <= '0;
    end else if (i_en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (tick) state_nx = RUN;
      RUN:     if (rlat == '0) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // dp_a doubles as the held sample: on a stale tick it simply keeps its value,
  // so the previous sample is re-launched.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      dp_a      <= '0;
      rlat      <= '0;
      o_signal  <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
      o_stale   <= 1'b0;
    end else begin
      o_valid <= (state == COMMIT);
      if (launch) begin
        rlat <= LW'(LAT - 1);
        if (i_valid) dp_a <= i_signal;
        else         o_stale <= 1'b1;
      end else if (state == RUN) begin
        rlat <= rlat - LW'(1);
      end
      if (tick && (state != IDLE)) o_overrun <= 1'b1;
      if (state == COMMIT) o_signal <= dp_nan ? '0 : dp_q;
    end
  end

endmodule

// File: tb/tb_iir_step_ctrl.sv
module tb_iir_step_ctrl;

  localparam logic [31:0] BASE = 32'hA000_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_l, reset2_l, i_en, i_en2, i_valid;
  logic [31:0] i_signal, dp_q;

  logic [31:0] dp_a, o_signal, dp_a2, o_signal2;
  logic        dp_en, o_upd, o_valid, o_overrun, o_stale;
  logic        dp_en2, o_upd2, o_valid2, o_overrun2, o_stale2;
`ifdef IIR_NAN_GUARD_EN
  logic        o_flush, o_flush2;
`endif

  iir_step_ctrl #(.T(20), .LAT(5), .W(32)) dut (
    .clk(clk), .reset_l(reset_l), .i_en(i_en), .i_valid(i_valid),
    .i_signal(i_signal), .dp_q(dp_q), .dp_a(dp_a), .dp_en(dp_en),
    .o_upd(o_upd), .o_signal(o_signal), .o_valid(o_valid),
    .o_overrun(o_overrun), .o_stale(o_stale)
`ifdef IIR_NAN_GUARD_EN
    , .o_flush(o_flush)
`endif
  );

  // Period shorter than the sample lifetime: the second tick lands in RUN.
  iir_step_ctrl #(.T(8), .LAT(8), .W(32), .CHK_PARAMS(1'b0)) dut2 (
    .clk(clk), .reset_l(reset2_l), .i_en(i_en2), .i_valid(i_valid),
    .i_signal(i_signal), .dp_q(dp_q), .dp_a(dp_a2), .dp_en(dp_en2),
    .o_upd(o_upd2), .o_signal(o_signal2), .o_valid(o_valid2),
    .o_overrun(o_overrun2), .o_stale(o_stale2)
`ifdef IIR_NAN_GUARD_EN
    , .o_flush(o_flush2)
`endif
  );

  int n_en = 0, n_upd = 0, n_val = 0, n_val2 = 0;
  always @(posedge clk) begin
    if (dp_en)    n_en   <= n_en + 1;
    if (o_upd)    n_upd  <= n_upd + 1;
    if (o_valid)  n_val  <= n_val + 1;
    if (o_valid2) n_val2 <= n_val2 + 1;
  end

  int total = 0, bad = 0, cyc = 0, nan_at = -1;
  int s_en, s_upd, s_val, s_val2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Cycle c = interval after the c-th rising edge since reset release;
  // sampling and driving happen at the falling edge. dp_q carries the cycle
  // number so capture timing is visible in o_signal.
  task automatic adv_to(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
      dp_q = (cyc == nan_at) ? 32'h7FC0_0000 : BASE + 32'(cyc);
    end
  endtask

  initial begin
    reset_l = 1'b0; reset2_l = 1'b0; i_en = 1'b0; i_en2 = 1'b0;
    i_valid = 1'b0; i_signal = '0; dp_q = '0;
    repeat (3) @(negedge clk);
    chk("rst_dp_a", dp_a, 32'h0);
    chk("rst_dp_en", 32'(dp_en), 32'h0);
    chk("rst_upd", 32'(o_upd), 32'h0);
    chk("rst_signal", o_signal, 32'h0);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_overrun", 32'(o_overrun), 32'h0);
    chk("rst_stale", 32'(o_stale), 32'h0);

    // Basic schedule, T=20 LAT=5.
    i_en = 1'b1; i_valid = 1'b1; i_signal = 32'h3F80_0000;
    reset_l = 1'b1; cyc = 0; dp_q = BASE;
    adv_to(19);
    s_en = n_en; s_upd = n_upd; s_val = n_val;
    chk("pre_tick_en", 32'(dp_en), 32'h0);
    chk("pre_tick_dp_a", dp_a, 32'h0);
    adv_to(20);
    chk("launch_en", 32'(dp_en), 32'h1);
    chk("launch_dp_a", dp_a, 32'h3F80_0000);
    adv_to(24);
    chk("last_en", 32'(dp_en), 32'h1);
    adv_to(25);
    chk("commit_en", 32'(dp_en), 32'h0);
    chk("commit_upd", 32'(o_upd), 32'h1);
    chk("commit_valid", 32'(o_valid), 32'h0);
    adv_to(26);
    chk("valid_pulse", 32'(o_valid), 32'h1);
    chk("valid_signal", o_signal, BASE + 32'd25);
    chk("upd_one_cycle", 32'(o_upd), 32'h0);
    adv_to(27);
    chk("valid_end", 32'(o_valid), 32'h0);
    chk("signal_held", o_signal, BASE + 32'd25);
    chk("en_cycles", 32'(n_en - s_en), 32'd5);
    chk("upd_count", 32'(n_upd - s_upd), 32'd1);
    chk("val_count", 32'(n_val - s_val), 32'd1);

    adv_to(30); i_signal = 32'h4000_0000;
    adv_to(40);
    chk("s2_dp_a", dp_a, 32'h4000_0000);
    chk("s2_stale", 32'(o_stale), 32'h0);
    adv_to(46);
    chk("s2_valid", 32'(o_valid), 32'h1);
    chk("s2_signal", o_signal, BASE + 32'd45);

    // Stale tick: previous sample re-launched.
    adv_to(50); i_valid = 1'b0; i_signal = 32'hDEAD_BEEF;
    adv_to(59);
    chk("stale_pre", 32'(o_stale), 32'h0);
    adv_to(60);
    chk("stale_dp_a", dp_a, 32'h4000_0000);
    chk("stale_launch", 32'(dp_en), 32'h1);
    chk("stale_flag", 32'(o_stale), 32'h1);
    adv_to(66);
    chk("stale_valid", 32'(o_valid), 32'h1);
    chk("stale_signal", o_signal, BASE + 32'd65);

    // Drop i_en mid-RUN: sample completes, then nothing until re-enabled.
    adv_to(70); i_valid = 1'b1; i_signal = 32'h3F80_0000;
    adv_to(79);
    s_en = n_en; s_upd = n_upd; s_val = n_val;
    adv_to(80);
    chk("s4_launch", 32'(dp_en), 32'h1);
    adv_to(82); i_en = 1'b0;
    adv_to(86);
    chk("s4_valid", 32'(o_valid), 32'h1);
    chk("s4_signal", o_signal, BASE + 32'd85);
    adv_to(130);
    chk("dis_en_cycles", 32'(n_en - s_en), 32'd5);
    chk("dis_upd_count", 32'(n_upd - s_upd), 32'd1);
    chk("dis_val_count", 32'(n_val - s_val), 32'd1);
    chk("dis_stale_sticky", 32'(o_stale), 32'h1);
    i_en = 1'b1;
    // Counter held at 2 while disabled, so the next tick is at cycle 147.
    adv_to(147);
    chk("reen_pre", 32'(dp_en), 32'h0);
    adv_to(148);
    chk("reen_launch", 32'(dp_en), 32'h1);
    chk("overrun_clear", 32'(o_overrun), 32'h0);

    // Reset during RUN.
    adv_to(150);
    s_upd = n_upd; s_val = n_val;
    reset_l = 1'b0;
    #1;
    chk("arst_dp_a", dp_a, 32'h0);
    chk("arst_dp_en", 32'(dp_en), 32'h0);
    chk("arst_signal", o_signal, 32'h0);
    chk("arst_stale", 32'(o_stale), 32'h0);
    repeat (3) @(negedge clk);
    reset_l = 1'b1; cyc = 0; dp_q = BASE; nan_at = 45;
    adv_to(19);
    chk("abort_no_upd", 32'(n_upd - s_upd), 32'd0);
    chk("abort_no_val", 32'(n_val - s_val), 32'd0);
    chk("rel_pre_tick", 32'(dp_en), 32'h0);
    adv_to(20);
    chk("rel_launch", 32'(dp_en), 32'h1);
    chk("rel_dp_a", dp_a, 32'h3F80_0000);

    // Inf/NaN result at commit (sample launched at cycle 39).
    adv_to(45);
`ifdef IIR_NAN_GUARD_EN
    chk("nan_upd", 32'(o_upd), 32'h0);
    chk("nan_flush", 32'(o_flush), 32'h1);
`else
    chk("nan_upd", 32'(o_upd), 32'h1);
`endif
    adv_to(46);
    chk("nan_valid", 32'(o_valid), 32'h1);
`ifdef IIR_NAN_GUARD_EN
    chk("nan_signal", o_signal, 32'h0);
    chk("nan_flush_end", 32'(o_flush), 32'h0);
`else
    chk("nan_signal", o_signal, 32'h7FC0_0000);
`endif
    nan_at = -1;

    // Overrun: T=8, LAT=8. Launch at 7, RUN 8..15, tick at 15 dropped,
    // COMMIT 16, next launch at 23.
    reset2_l = 1'b1; i_en2 = 1'b1; cyc = 0; dp_q = BASE;
    s_val2 = n_val2;
    adv_to(15);
    chk("ov_pre", 32'(o_overrun2), 32'h0);
    chk("ov_run_en", 32'(dp_en2), 32'h1);
    adv_to(16);
    chk("ov_flag", 32'(o_overrun2), 32'h1);
    chk("ov_commit_upd", 32'(o_upd2), 32'h1);
    chk("ov_no_relaunch", 32'(dp_en2), 32'h0);
    adv_to(17);
    chk("ov_valid", 32'(o_valid2), 32'h1);
    chk("ov_signal", o_signal2, BASE + 32'd16);
    adv_to(24);
    chk("ov_next_launch", 32'(dp_en2), 32'h1);
    adv_to(40);
    chk("ov_val_count", 32'(n_val2 - s_val2), 32'd2);
    chk("ov_sticky", 32'(o_overrun2), 32'h1);
    chk("ov_stale", 32'(o_stale2), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
